// File: rtl/aes_pkg.sv
// Shared types, sizes and byte/word helpers for the AES-128 key expansion path.
package aes_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned NUM_WORDS = 44;
  localparam int unsigned IDX_W     = 6;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } keyexp_state_t;

  // GF(2^8) multiply-by-x with the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Cyclic left rotate by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0]
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, 256-entry ROM, 8 bits in / 8 bits out.
module aes_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data_c
);

  // Rows listed in natural order, so entry 0x00 sits at the top; index with ~x.
  localparam logic [255:0][7:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_data_c = SBOX_ROM[~i_data];

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule generator: one word per cycle, or one round key
// per cycle when AES_KEYEXP_FAST_EN is defined.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic [KEY_W-1:0]                 i_cipherkey,
  output logic [128*(NUM_ROUNDS+1)-1:0]    o_key_schedule,
  output logic                             o_busy,
  output logic                             o_done
);

  keyexp_state_t          r_state, w_state_nxt;
  word_t [NUM_WORDS-1:0]  r_ks, w_ks_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [7:0]             r_rcon, w_rcon_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;

  word_t                  w_prev;
  word_t                  w_rot;
  word_t                  w_rcon_word;
  wire  [WORD_W-1:0]      w_sub;

  assign w_prev      = r_ks[r_idx - IDX_W'(1)];
  assign w_rot       = rot_word(w_prev);
  assign w_rcon_word = {r_rcon, 24'h000000};

  // SubWord: one S-box per byte of the rotated previous word
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .i_data   (w_rot[8*b +: 8]),
      .o_data_c (w_sub[8*b +: 8])
    );
  end

`ifdef AES_KEYEXP_FAST_EN
  // Full round key per cycle: the four words chain through an XOR ripple
  word_t w_n0, w_n1, w_n2, w_n3;
  assign w_n0 = r_ks[r_idx - IDX_W'(4)] ^ w_sub ^ w_rcon_word;
  assign w_n1 = r_ks[r_idx - IDX_W'(3)] ^ w_n0;
  assign w_n2 = r_ks[r_idx - IDX_W'(2)] ^ w_n1;
  assign w_n3 = w_prev ^ w_n2;
`else
  word_t w_temp, w_new;
  assign w_temp = (r_idx[1:0] == 2'b00) ? (w_sub ^ w_rcon_word) : w_prev;
  assign w_new  = r_ks[r_idx - IDX_W'(4)] ^ w_temp;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_ks    <= '0;
      r_idx   <= '0;
      r_rcon  <= RCON_INIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ks    <= w_ks_nxt;
      r_idx   <= w_idx_nxt;
      r_rcon  <= w_rcon_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ks_nxt    = r_ks;
    w_idx_nxt   = r_idx;
    w_rcon_nxt  = r_rcon;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;

    case (r_state)
      IDLE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        if (i_start) begin
          w_ks_nxt[0] = i_cipherkey[127:96];
          w_ks_nxt[1] = i_cipherkey[95:64];
          w_ks_nxt[2] = i_cipherkey[63:32];
          w_ks_nxt[3] = i_cipherkey[31:0];
          w_idx_nxt   = IDX_W'(4);
          w_rcon_nxt  = RCON_INIT;
          w_busy_nxt  = 1'b1;
          w_state_nxt = EXPAND;
        end
      end

      EXPAND: begin
`ifdef AES_KEYEXP_FAST_EN
        w_ks_nxt[r_idx]                = w_n0;
        w_ks_nxt[r_idx + IDX_W'(1)]    = w_n1;
        w_ks_nxt[r_idx + IDX_W'(2)]    = w_n2;
        w_ks_nxt[r_idx + IDX_W'(3)]    = w_n3;
        w_rcon_nxt = xtime(r_rcon);
        if (r_idx == IDX_W'(NUM_WORDS - 4)) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(4);
        end
`else
        w_ks_nxt[r_idx] = w_new;
        if (r_idx[1:0] == 2'b00) begin
          w_rcon_nxt = xtime(r_rcon);
        end
        // Index parks on the last word so it never leaves the schedule range
        if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
`endif
      end

      DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
        if (!i_start) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_key_schedule = r_ks;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using the FIPS-197 A.1 and C.1 keys.
module tb_aes_key_expander;

  localparam int unsigned KS_W = 1408;
`ifdef AES_KEYEXP_FAST_EN
  localparam int LAT = 11;
  localparam int MID = 4;
`else
  localparam int LAT = 41;
  localparam int MID = 16;
`endif

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

  // A.1 round keys in word order (w[4r] leftmost)
  localparam logic [127:0] A1_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] C1_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [127:0]    key;
  logic [KS_W-1:0] ks;
  logic            busy;
  logic            done;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  aes_key_expander #(.NUM_ROUNDS(10)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_cipherkey    (key),
    .o_key_schedule (ks),
    .o_busy         (busy),
    .o_done         (done)
  );

  // Word i lives at bits [32i+31:32i], so a round key slice is word-reversed
  function automatic logic [127:0] wrev(input logic [127:0] x);
    return {x[31:0], x[63:32], x[95:64], x[127:96]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_a1(input string pfx);
    for (int r = 0; r <= 10; r++)
      check($sformatf("%s_rk%0d", pfx, r), ks[128*r +: 128], wrev(A1_RK[r]));
  endtask

  task automatic check_zero(input string pfx);
    for (int r = 0; r <= 10; r++)
      check($sformatf("%s_zero_rk%0d", pfx, r), ks[128*r +: 128], 128'd0);
  endtask

  task automatic wait_done(input int e0, output int edges, output int bc);
    edges = e0;
    bc    = 0;
    while (!done && edges < 200) begin
      tick();
      edges++;
      if (busy) bc++;
    end
  endtask

  int e;
  int bc;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    key   = '0;
    tick();
    tick();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check_zero("rst");
    rst = 1'b0;
    tick();
    check("idle_done", 128'(done), 128'd0);

    // Basic A.1 expansion with Start held high
    key   = KEY_A1;
    start = 1'b1;
    tick();
    check("t1_busy_start", 128'(busy), 128'd1);
    check("t1_done_early", 128'(done), 128'd0);
    wait_done(1, e, bc);
    check("t1_latency", 128'(e), 128'(LAT));
    check("t1_busy_cycles", 128'(bc + 1), 128'(LAT - 1));
    check("t1_w4", 128'(ks[159:128]), 128'h00000000_00000000_00000000_a0fafe17);
    check_a1("t1");
    tick();
    tick();
    tick();
    check("t1_hold_done", 128'(done), 128'd1);
    check("t1_hold_busy", 128'(busy), 128'd0);
    start = 1'b0;
    tick();
    check("t1_done_fall", 128'(done), 128'd0);
    check("t1_idle_rk10", ks[1280 +: 128], wrev(A1_RK[10]));

    // Back-to-back with the C.1 key
    key   = KEY_C1;
    start = 1'b1;
    tick();
    wait_done(1, e, bc);
    check("t5_latency", 128'(e), 128'(LAT));
    check("t5_rk0", ks[0 +: 128], wrev(KEY_C1));
    check("t5_rk1", ks[128 +: 128], wrev(C1_RK1));
    check("t5_rk10", ks[1280 +: 128], wrev(C1_RK10));
    start = 1'b0;
    tick();

    // Start dropped mid-expansion: no abort, single-cycle Done
    key   = KEY_A1;
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    wait_done(3, e, bc);
    check("t2_latency", 128'(e), 128'(LAT));
    tick();
    check("t2_done_1cyc", 128'(done), 128'd0);
    check("t2_busy_idle", 128'(busy), 128'd0);
    check_a1("t2");

    // Reset at word index 20
    key   = KEY_C1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (MID) tick();
    check("t3_busy_mid", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t3_busy_rst", 128'(busy), 128'd0);
    check("t3_done_rst", 128'(done), 128'd0);
    check_zero("t3");
    tick();
    check("t3_idle_busy", 128'(busy), 128'd0);
    key   = KEY_A1;
    start = 1'b1;
    tick();
    wait_done(1, e, bc);
    check("t3_latency", 128'(e), 128'(LAT));
    check_a1("t3");
    start = 1'b0;
    tick();

    // Cipherkey changes after the latch edge are ignored
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    key   = KEY_A1;
    start = 1'b1;
    tick();
    tick();
    key = '0;
    wait_done(2, e, bc);
    check("t4_latency", 128'(e), 128'(LAT));
    check_a1("t4");
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequential AES-128 key-expansion engine. It sits directly upstream of the decryption state driver.
- Latches a 128-bit cipher key on Start and computes the 44-word (1408-bit) key schedule iteratively, one word per cycle.
- Raises Done once the schedule is valid, and holds the schedule stable for the decryption state machine to index.

Parameters:
- NUM_ROUNDS, 10, AES round count. Only 10 is legal. Fixes schedule width at 128*(NUM_ROUNDS+1) = 1408.

Ports:
- Clk  in  1  system clock, all state updates on posedge.
- Reset  in  1  synchronous active-high reset.
- Start  in  1  level-sensitive start request (same handshake style as the decrypt start flag).
- Cipherkey  in  128  key; word w0 = Cipherkey[127:96], w3 = Cipherkey[31:0].
- KeySchedule  out  1408  word i at bits [32i+31:32i]; round key r at [128r+127:128r].
- Busy  out  1  high while expansion is in progress.
- Done  out  1  schedule valid; held until Start falls.

Behaviour:
- Interface: one clock (Clk); reset (Reset) is synchronous and active-high. Reset dominates all other inputs.
- Reset values: KeySchedule = 0, Busy = 0, Done = 0, state = IDLE, word index = 0, rcon = 8'h01.
- States:
  - IDLE: if Start, latch Cipherkey into w0..w3, set index i = 4, rcon = 01, Busy = 1, go to EXPAND.
  - EXPAND: each cycle write w[i] = w[i-4] ^ temp.
    - temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i%4 == 0; otherwise temp = w[i-1].
    - After an i%4 == 0 word, rcon <= xtime(rcon): 01→02→…→80→1B→36.
    - When i == 43 is written, go to DONE.
  - DONE: Done = 1, Busy = 0. If Start is low, go to IDLE.
- Latency: the Start-sampling edge plus 40 EXPAND edges. Done is high in the cycle after w43 is written, i.e. 41 edges after Start is sampled.
- Cipherkey changes after the latch edge are ignored.
- Start dropping mid-expansion does not abort. Expansion completes, DONE is entered, and it exits next edge, so Done is high for exactly 1 cycle.
- KeySchedule holds its last value in IDLE and DONE. A new Start overwrites it word by word; consumers must not read until Done.
- Words above the current index are undefined-but-stable (old values) while Busy.
- Reset mid-EXPAND: next cycle IDLE, schedule zeroed, Done/Busy = 0.
- Start held high continuously: IDLE→EXPAND→DONE, then stays in DONE (no auto-restart).
- Index counter is 6 bits and never exceeds 43. Rcon register is 8 bits; xtime = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 0).

Optional Feature:
- Macro: AES_KEYEXP_FAST_EN.
- Defined: EXPAND computes a full round key (4 chained words, 4 words' XOR ripple) per cycle.
  - Index steps by 4; rcon advances every cycle.
  - 10 EXPAND cycles; Done 11 edges after Start is sampled.
  - Still only one SubWord per cycle: 4 S-box instances.
- Undefined: 1 word/cycle as above, 41-edge latency.
- All other behaviour (reset, handshake, layout) is identical in both modes.

Decomposition:
- Package aes_pkg:
  - word_t (logic [31:0]).
  - keyexp_state_t enum {IDLE, EXPAND, DONE}.
  - NUM_WORDS = 44.
  - xtime() and rot_word() functions.
  - RCON_INIT = 8'h01.
- Sub-module aes_sbox: combinational 256-entry forward S-box ROM, 8-in/8-out.
  - SubWord = 4 instances, in both modes.
  - The inverse S-box used by decrypt is a separate module.

Test Plan:
1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, Start = 1 → after 41 edges Done = 1.
   - KeySchedule[159:128] = a0fafe17.
   - Round key 1 = a0fafe1788542cb123a339392a6c7605.
   - Round key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Round key 0 = cipher key.
2. Same key, Start held 3 cycles then dropped mid-EXPAND → identical schedule; Done high exactly 1 cycle; back to IDLE.
3. Reset asserted at EXPAND index 20 → next cycle KeySchedule = 0, Busy = 0, Done = 0. Restart with the A.1 key gives the full correct result.
4. Cipherkey changed to all-zero 2 cycles after start → schedule still matches the A.1 key.
5. Back-to-back: second key 000102030405060708090a0b0c0d0e0f after Start low/high → round key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
6. With AES_KEYEXP_FAST_EN → test 1 vectors with Done at edge 11; Busy high for exactly 10 cycles.
